// File: rtl/oled_arb_pkg.sv
// Shared types and constants for the frame-synchronous OLED pixel-stream arbiter.
// Holds the display geometry, colour constants and the round-robin index helper.
package oled_arb_pkg;

  localparam int OLED_W      = 96;
  localparam int OLED_H      = 64;
  localparam int OLED_PIXELS = OLED_W * OLED_H;

  localparam logic [15:0] COL_BLACK = 16'h0000;
  localparam logic [15:0] COL_WHITE = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN   = 2'd1,
    BLANK = 2'd2
  } arb_state_t;

  // Next requester index after idx, wrapping at n (n is at most 8).
  function automatic logic [2:0] rr_inc(input logic [2:0] idx, input int unsigned n);
    logic [3:0] nxt;
    nxt = {1'b0, idx} + 4'd1;
    if (nxt >= 4'(n)) begin
      rr_inc = 3'd0;
    end else begin
      rr_inc = nxt[2:0];
    end
  endfunction

endpackage

// File: rtl/oled_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after start, wrapping,
// optionally skipping one index (the current owner).
module oled_rr_pick
  import oled_arb_pkg::*;
#(
  parameter int N_REQ = 5
) (
  input  logic [N_REQ-1:0] req,
  input  logic [2:0]       start,
  input  logic             exclude_en,
  input  logic [2:0]       exclude_idx,
  output logic             found,
  output logic [2:0]       idx
);

  // Scan all N_REQ candidates in priority order from start.
  always_comb begin
    logic [2:0] cand;
    found = 1'b0;
    idx   = 3'd0;
    cand  = start;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req[cand] && !(exclude_en && (cand == exclude_idx))) begin
        found = 1'b1;
        idx   = cand;
      end else begin
        found = found;
      end
      cand = rr_inc(cand, N_REQ);
    end
  end

endmodule

// File: rtl/oled_frame_arbiter.sv
// Frame-synchronous round-robin arbiter sharing the OLED pixel stream between sources.
// Optional feature: define OLED_ARB_BLANK_EN to insert one blank frame between owners.
module oled_frame_arbiter
  import oled_arb_pkg::*;
#(
  parameter int          N_REQ       = 5,
  parameter int          MIN_FRAMES  = 4,
  parameter logic [15:0] IDLE_COLOUR = 16'h0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_begin,
  input  logic [12:0]          pixel_index,
  input  logic [N_REQ-1:0]     req,
  input  logic [16*N_REQ-1:0]  pixel_in,
  output logic [15:0]          pixel_data,
  output logic [N_REQ-1:0]     grant,
  output logic [2:0]           owner_id,
  output logic                 busy
);

  localparam logic [7:0] HOLD_RELOAD = 8'(MIN_FRAMES - 1);
  localparam logic [2:0] LAST_RESET  = 3'(N_REQ - 1);

  arb_state_t       state_r, state_s;
  logic [2:0]       owner_r, owner_s;
  logic [7:0]       hold_r, hold_s;
  logic [2:0]       last_r, last_s;
  logic [N_REQ-1:0] grant_r, grant_s;
  logic [2:0]       owner_id_r, owner_id_s;
  logic             busy_r, busy_s;

  logic             frame_s;
  logic             switch_s;
  logic [2:0]       pick_start_s;
  logic             pick_excl_s;
  logic             pick_found_s;
  logic [2:0]       pick_idx_s;

  // A frame start only counts while the driver reports an on-screen pixel index.
  assign frame_s = frame_begin && (pixel_index < 13'(OLED_PIXELS));

  // From IDLE the scan starts after the last owner; in OWN after the owner, skipping it.
  always_comb begin
    if (state_r == OWN) begin
      pick_start_s = rr_inc(owner_r, N_REQ);
      pick_excl_s  = 1'b1;
    end else begin
      pick_start_s = rr_inc(last_r, N_REQ);
      pick_excl_s  = 1'b0;
    end
  end

  oled_rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req         (req),
    .start       (pick_start_s),
    .exclude_en  (pick_excl_s),
    .exclude_idx (owner_r),
    .found       (pick_found_s),
    .idx         (pick_idx_s)
  );

  // Next-state logic; everything holds except on a qualified frame start.
  always_comb begin
    state_s  = state_r;
    owner_s  = owner_r;
    hold_s   = hold_r;
    last_s   = last_r;
    switch_s = 1'b0;
    if (frame_s) begin
      case (state_r)
        IDLE: begin
          if (pick_found_s) begin
            state_s = OWN;
            owner_s = pick_idx_s;
            hold_s  = HOLD_RELOAD;
            last_s  = pick_idx_s;
          end else begin
            state_s = IDLE;
          end
        end
        OWN: begin
          if (!req[owner_r]) begin
            if (pick_found_s) begin
              switch_s = 1'b1;
            end else begin
              state_s = IDLE;
              hold_s  = 8'd0;
            end
          end else if (hold_r != 8'd0) begin
            hold_s = hold_r - 8'd1;
          end else if (pick_found_s) begin
            switch_s = 1'b1;
          end else begin
            hold_s = 8'd0;
          end
        end
`ifdef OLED_ARB_BLANK_EN
        BLANK: begin
          // The winner was fixed on entry; it only has to still be asking.
          if (req[owner_r]) begin
            state_s = OWN;
            hold_s  = HOLD_RELOAD;
            last_s  = owner_r;
          end else begin
            state_s = IDLE;
            hold_s  = 8'd0;
          end
        end
`endif
        default: begin
          state_s = IDLE;
          hold_s  = 8'd0;
        end
      endcase

      if (switch_s) begin
`ifdef OLED_ARB_BLANK_EN
        state_s = BLANK;
        owner_s = pick_idx_s;
        hold_s  = 8'd0;
`else
        state_s = OWN;
        owner_s = pick_idx_s;
        hold_s  = HOLD_RELOAD;
        last_s  = pick_idx_s;
`endif
      end else begin
        owner_s = owner_s;
      end
    end else begin
      state_s = state_r;
    end
  end

  // Output values that the next state implies, so the registered outputs line up with it.
  always_comb begin
    grant_s    = '0;
    owner_id_s = 3'd0;
    busy_s     = (state_s != IDLE);
    if (state_s == OWN) begin
      grant_s[owner_s] = 1'b1;
      owner_id_s       = owner_s;
    end else begin
      owner_id_s = 3'd0;
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      owner_r    <= 3'd0;
      hold_r     <= 8'd0;
      last_r     <= LAST_RESET;
      grant_r    <= '0;
      owner_id_r <= 3'd0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      owner_r    <= owner_s;
      hold_r     <= hold_s;
      last_r     <= last_s;
      grant_r    <= grant_s;
      owner_id_r <= owner_id_s;
      busy_r     <= busy_s;
    end
  end

  // Pixel mux is combinational from registered state so no pixel latency is added.
  always_comb begin
    pixel_data = IDLE_COLOUR;
    if (state_r == OWN) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (owner_r == 3'(i)) begin
          pixel_data = pixel_in[16*i +: 16];
        end else begin
          pixel_data = pixel_data;
        end
      end
    end else begin
      pixel_data = IDLE_COLOUR;
    end
  end

  assign grant    = grant_r;
  assign owner_id = owner_id_r;
  assign busy     = busy_r;

endmodule
